// File: rtl/bus_xfer_pkg.sv
// Shared state encoding and default sizes for the bus transfer sequencer.
// The swap states are only reached when XFER_SWAP_EN is defined.
package bus_xfer_pkg;

  localparam int NREG_DEF        = 8;
  localparam int IDX_W_DEF       = 3;
  localparam int DATA_W_DEF      = 8;
  localparam int SCRATCH_IDX_DEF = 7;

  // S_SWAPn covers one drive/write pair of a swap; a phase bit splits it.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_SWAP1 = 3'd4,
    S_SWAP2 = 3'd5,
    S_SWAP3 = 3'd6
  } xfer_state_t;

endpackage

// File: rtl/bus_xfer_seq_onehot_dec.sv
// Index-to-one-hot decoder; yields all zeros when disabled or when the
// index does not name an existing register.
module onehot_dec #(
  parameter int NREG  = 8,
  parameter int IDX_W = 3
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [NREG-1:0]  vec
);

  always_comb begin
    vec = '0;
    for (int i = 0; i < NREG; i++)
      if (en && int'(idx) == i) vec[i] = 1'b1;
  end

endmodule

// File: rtl/bus_xfer_seq.sv
// Register-transfer sequencer driving one-hot output/write enables of a
// tri-state register bank. Optional three-step swap under XFER_SWAP_EN.
module bus_xfer_seq
  import bus_xfer_pkg::*;
#(
  parameter int NREG        = NREG_DEF,
  parameter int IDX_W       = IDX_W_DEF,
  parameter int DATA_W      = DATA_W_DEF
`ifdef XFER_SWAP_EN
  ,
  parameter int SCRATCH_IDX = SCRATCH_IDX_DEF
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IDX_W-1:0]  req_src,
  input  logic [IDX_W-1:0]  req_dst,
  input  logic              req_imm_en,
  input  logic [DATA_W-1:0] req_imm,
`ifdef XFER_SWAP_EN
  input  logic              req_swap,
`endif
  output logic [NREG-1:0]   out_en,
  output logic [NREG-1:0]   write_en,
  output logic              imm_oe,
  output logic [DATA_W-1:0] imm_out,
  output logic              done,
  output logic              err
);

  xfer_state_t       state;
  logic [IDX_W-1:0]  src_q, dst_q;
  logic              imm_en_q, err_q;
  logic [DATA_W-1:0] imm_q;
  logic              accept, bad, nop;
  logic              drv_en, wr_en;
  logic [IDX_W-1:0]  drv_idx, wr_idx;
  logic [NREG-1:0]   wr_vec;

`ifdef XFER_SWAP_EN
  localparam logic [IDX_W-1:0] SCR = IDX_W'(SCRATCH_IDX);
  logic swap_req, wr_ph;
  assign swap_req = req_swap && !req_imm_en;
`endif

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    bad = (int'(req_dst) >= NREG) || (!req_imm_en && int'(req_src) >= NREG);
    nop = !req_imm_en && (req_src == req_dst);
`ifdef XFER_SWAP_EN
    // The scratch register cannot take part in its own swap.
    if (swap_req && (req_src == SCR || req_dst == SCR)) bad = 1'b1;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      imm_en_q <= 1'b0;
      imm_q    <= '0;
      err_q    <= 1'b0;
`ifdef XFER_SWAP_EN
      wr_ph    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          src_q    <= req_src;
          dst_q    <= req_dst;
          imm_en_q <= req_imm_en;
          imm_q    <= req_imm;
          err_q    <= bad;
`ifdef XFER_SWAP_EN
          wr_ph    <= 1'b0;
          state    <= (bad || nop) ? S_DONE : (swap_req ? S_SWAP1 : S_DRIVE);
`else
          state    <= (bad || nop) ? S_DONE : S_DRIVE;
`endif
        end
        S_DRIVE: state <= S_WRITE;
        S_WRITE: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
`ifdef XFER_SWAP_EN
        S_SWAP1: begin
          wr_ph <= !wr_ph;
          if (wr_ph) state <= S_SWAP2;
        end
        S_SWAP2: begin
          wr_ph <= !wr_ph;
          if (wr_ph) state <= S_SWAP3;
        end
        S_SWAP3: begin
          wr_ph <= !wr_ph;
          if (wr_ph) state <= S_DONE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode only registered state and captured fields.
  always_comb begin
    drv_en  = 1'b0;
    drv_idx = src_q;
    wr_en   = 1'b0;
    wr_idx  = dst_q;
    imm_oe  = 1'b0;
    case (state)
      S_DRIVE: begin
        drv_en = !imm_en_q;
        imm_oe = imm_en_q;
      end
      S_WRITE: begin
        drv_en = !imm_en_q;
        imm_oe = imm_en_q;
        wr_en  = 1'b1;
      end
`ifdef XFER_SWAP_EN
      S_SWAP1: begin
        drv_en = 1'b1;
        wr_idx = SCR;
        wr_en  = wr_ph;
      end
      S_SWAP2: begin
        drv_en  = 1'b1;
        drv_idx = dst_q;
        wr_idx  = src_q;
        wr_en   = wr_ph;
      end
      S_SWAP3: begin
        drv_en  = 1'b1;
        drv_idx = SCR;
        wr_en   = wr_ph;
      end
`endif
      default: ;
    endcase
  end

  onehot_dec #(.NREG(NREG), .IDX_W(IDX_W)) u_oe_dec (
    .idx (drv_idx),
    .en  (drv_en),
    .vec (out_en)
  );

  onehot_dec #(.NREG(NREG), .IDX_W(IDX_W)) u_we_dec (
    .idx (wr_idx),
    .en  (wr_en),
    .vec (wr_vec)
  );

  // Reset during a write cycle must suppress the write on that same edge.
  assign write_en = wr_vec & {NREG{!reset}};
  assign imm_out  = imm_q;
  assign done     = (state == S_DONE);
  assign err      = done && err_q;

endmodule
